// File: rtl/cmp_debounce_fsm.sv
// cmp_debounce_fsm: debounces the eq/gt/lt outputs of the 8-bit comparator.
//
// A new relation is accepted only after HOLD consecutive identical legal
// valid samples. Acceptance happens at the same edge that samples the
// HOLD-th identical sample. Outputs are a registered relation state, its
// one-hot decodes, a one-cycle change pulse, a wrapping event counter and
// a sticky error flag for illegal flag combinations.
//
// Optional feature, macro CMP_TIMEOUT_EN: after TIMEOUT consecutive cycles
// with in_valid=0, a non-IDLE state falls back to IDLE. This counts as a
// change. Without the macro no idle counter exists and TIMEOUT is unused.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   in_valid     eq/gt/lt are sampled this cycle
//   eq, gt, lt   comparator flags
//   clear        synchronous soft clear, same effect as rst
//   state_o      debounced relation: 00 IDLE, 01 MATCH, 10 ABOVE, 11 BELOW
//   above/below/match  decodes of state_o
//   change_pulse one-cycle pulse on the cycle state_o changes
//   evt_cnt      number of accepted relation changes (wraps)
//   err          sticky illegal-sample flag
module cmp_debounce_fsm #(
  parameter int unsigned HOLD    = 3,
  parameter int unsigned EVT_W   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             eq,
  input  logic             gt,
  input  logic             lt,
  input  logic             clear,
  output logic [1:0]       state_o,
  output logic             above,
  output logic             below,
  output logic             match,
  output logic             change_pulse,
  output logic [EVT_W-1:0] evt_cnt,
  output logic             err
);

  localparam int unsigned RUN_W  = 4;
  localparam int unsigned IDLE_W = 8;

  // Parameter range checks at elaboration.
  if (HOLD < 1 || HOLD > 15) begin : g_bad_hold
    $error("cmp_debounce_fsm: HOLD must be in 1..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("cmp_debounce_fsm: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_MATCH = 2'b01,
    ST_ABOVE = 2'b10,
    ST_BELOW = 2'b11
  } rel_e;

  rel_e             state_q, state_d;
  rel_e             cand_q, cand_d;
  rel_e             code;
  logic [RUN_W-1:0] run_q, run_d;
  logic             pulse_q, pulse_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic             err_q, err_d;
  logic             legal;

`ifdef CMP_TIMEOUT_EN
  logic [IDLE_W-1:0] idle_q, idle_d;
`endif

  // State register; rst and clear override every other event.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= ST_IDLE;
      cand_q  <= ST_IDLE;
      run_q   <= '0;
      pulse_q <= 1'b0;
      evt_q   <= '0;
      err_q   <= 1'b0;
`ifdef CMP_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      run_q   <= run_d;
      pulse_q <= pulse_d;
      evt_q   <= evt_d;
      err_q   <= err_d;
`ifdef CMP_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

  // Run tracking, acceptance and illegal-sample handling.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    run_d   = run_q;
    pulse_d = 1'b0;
    evt_d   = evt_q;
    err_d   = err_q;
    legal   = ({eq, gt, lt} == 3'b100) || ({eq, gt, lt} == 3'b010) ||
              ({eq, gt, lt} == 3'b001);
    code    = eq ? ST_MATCH : (gt ? ST_ABOVE : ST_BELOW);
`ifdef CMP_TIMEOUT_EN
    idle_d  = idle_q;
`endif

    if (in_valid) begin
      if (legal) begin
        if (code == cand_q) begin
          // Run saturates at HOLD so sustained samples never re-trigger.
          run_d = (run_q >= RUN_W'(HOLD)) ? RUN_W'(HOLD) : run_q + RUN_W'(1);
        end else begin
          cand_d = code;
          run_d  = RUN_W'(1);
        end
        if (run_d == RUN_W'(HOLD) && cand_d != state_q) begin
          state_d = cand_d;
          pulse_d = 1'b1;
          evt_d   = evt_q + EVT_W'(1);
        end
      end else begin
        err_d = 1'b1;
        run_d = '0;
      end
    end

`ifdef CMP_TIMEOUT_EN
    // Idle counter saturates at TIMEOUT; it only fires on its way up.
    if (in_valid) begin
      idle_d = '0;
    end else if (idle_q < IDLE_W'(TIMEOUT)) begin
      idle_d = idle_q + IDLE_W'(1);
    end
    if (!in_valid && idle_q == IDLE_W'(TIMEOUT - 1) && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      cand_d  = ST_IDLE;
      run_d   = '0;
      pulse_d = 1'b1;
      evt_d   = evt_q + EVT_W'(1);
      idle_d  = '0;
    end
`endif
  end

  assign state_o      = state_q;
  assign match        = (state_q == ST_MATCH);
  assign above        = (state_q == ST_ABOVE);
  assign below        = (state_q == ST_BELOW);
  assign change_pulse = pulse_q;
  assign evt_cnt      = evt_q;
  assign err          = err_q;

endmodule

// File: tb/tb_cmp_debounce_fsm.sv
// Bench for cmp_debounce_fsm (HOLD=3, EVT_W=8, timeout feature off).
// Directed vector table, an event-counter wrap run, then random stimulus
// against a reference model. The model keeps the recent legal codes in a
// queue and accepts when the last HOLD codes agree.
module tb_cmp_debounce_fsm;

  localparam int unsigned HOLD  = 3;
  localparam int unsigned EVT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             eq = 1'b0;
  logic             gt = 1'b0;
  logic             lt = 1'b0;
  logic             clear = 1'b0;
  logic [1:0]       state_o;
  logic             above, below, match, change_pulse, err;
  logic [EVT_W-1:0] evt_cnt;

  int total = 0;
  int bad   = 0;

  cmp_debounce_fsm #(.HOLD(HOLD), .EVT_W(EVT_W), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .eq(eq), .gt(gt), .lt(lt),
    .clear(clear), .state_o(state_o), .above(above), .below(below),
    .match(match), .change_pulse(change_pulse), .evt_cnt(evt_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model state.
  int m_state = 0;
  int m_pulse = 0;
  int m_evt   = 0;
  int m_err   = 0;
  int hist[$];

  task automatic model_step(input logic r, input logic c, input logic v,
                            input logic e, input logic g, input logic l);
    int code;
    int agree;
    m_pulse = 0;
    if (r || c) begin
      m_state = 0; m_evt = 0; m_err = 0;
      hist.delete();
    end else if (v) begin
      if (int'(e) + int'(g) + int'(l) != 1) begin
        m_err = 1;
        hist.delete();
      end else begin
        code = e ? 1 : (g ? 2 : 3);
        hist.push_back(code);
        if (hist.size() > HOLD) void'(hist.pop_front());
        agree = (hist.size() == HOLD);
        foreach (hist[k]) if (hist[k] != code) agree = 0;
        if (agree != 0 && code != m_state) begin
          m_state = code;
          m_pulse = 1;
          m_evt   = (m_evt + 1) % (1 << EVT_W);
        end
      end
    end
  endtask

  // Drive one cycle's inputs, clock it, sample #1 after the edge.
  task automatic cyc(input logic r, input logic c, input logic v,
                     input logic e, input logic g, input logic l);
    rst = r; clear = c; in_valid = v; eq = e; gt = g; lt = l;
    @(posedge clk);
    model_step(r, c, v, e, g, l);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int pl,
                         input int ev, input int er);
    chk({tag, " state"}, int'(state_o), st);
    chk({tag, " pulse"}, int'(change_pulse), pl);
    chk({tag, " evt"}, int'(evt_cnt), ev);
    chk({tag, " err"}, int'(err), er);
    chk({tag, " decode"}, int'({match, above, below}),
        int'({st == 1, st == 2, st == 3}));
  endtask

  typedef struct {
    logic r, c, v, e, g, l;
    int st, pl, ev, er;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic c, input logic v,
                              input logic e, input logic g, input logic l,
                              input int st, input int pl, input int ev,
                              input int er);
    vec_t t;
    t.r = r; t.c = c; t.v = v; t.e = e; t.g = g; t.l = l;
    t.st = st; t.pl = pl; t.ev = ev; t.er = er;
    tbl.push_back(t);
  endfunction

  initial begin
    // Basic acceptance of ABOVE, then sustained and idle cycles.
    add(1,0,0,0,0,0, 0,0,0,0);
    add(0,0,1,0,1,0, 0,0,0,0);
    add(0,0,1,0,1,0, 0,0,0,0);
    add(0,0,1,0,1,0, 2,1,1,0);
    add(0,0,1,0,1,0, 2,0,1,0);
    add(0,0,0,0,0,0, 2,0,1,0);
    // gt,gt,lt,gt,gt,gt: only the sixth sample accepts.
    add(1,0,0,0,0,0, 0,0,0,0);
    add(0,0,1,0,1,0, 0,0,0,0);
    add(0,0,1,0,1,0, 0,0,0,0);
    add(0,0,1,0,0,1, 0,0,0,0);
    add(0,0,1,0,1,0, 0,0,0,0);
    add(0,0,1,0,1,0, 0,0,0,0);
    add(0,0,1,0,1,0, 2,1,1,0);
    add(0,0,1,0,1,0, 2,0,1,0);
    // eq x2, gap of 5, eq: gap does not break the run.
    add(1,0,0,0,0,0, 0,0,0,0);
    add(0,0,1,1,0,0, 0,0,0,0);
    add(0,0,1,1,0,0, 0,0,0,0);
    for (int i = 0; i < 5; i++) add(0,0,0,0,0,0, 0,0,0,0);
    add(0,0,1,1,0,0, 1,1,1,0);
    // MATCH -> BELOW is a second change.
    add(0,0,1,0,0,1, 1,0,1,0);
    add(0,0,1,0,0,1, 1,0,1,0);
    add(0,0,1,0,0,1, 3,1,2,0);
    // Illegal gt+lt sets err; then gt x3 accepts ABOVE; clear resets all.
    add(1,0,0,0,0,0, 0,0,0,0);
    add(0,0,1,0,1,1, 0,0,0,1);
    add(0,0,1,0,1,0, 0,0,0,1);
    add(0,0,1,0,1,0, 0,0,0,1);
    add(0,0,1,0,1,0, 2,1,1,1);
    add(0,1,0,0,0,0, 0,0,0,0);
    // Illegal no-flag sample breaks a run mid-way.
    add(0,0,1,0,1,0, 0,0,0,0);
    add(0,0,1,0,1,0, 0,0,0,0);
    add(0,0,1,0,0,0, 0,0,0,1);
    add(0,0,1,0,1,0, 0,0,0,1);
    add(0,0,1,0,1,0, 0,0,0,1);
    add(0,0,1,0,1,0, 2,1,1,1);
    // clear with the 3rd lt: sample dropped, run restarts.
    add(1,0,0,0,0,0, 0,0,0,0);
    add(0,0,1,0,0,1, 0,0,0,0);
    add(0,0,1,0,0,1, 0,0,0,0);
    add(0,1,1,0,0,1, 0,0,0,0);
    add(0,0,1,0,0,1, 0,0,0,0);
    add(0,0,1,0,0,1, 0,0,0,0);
    add(0,0,1,0,0,1, 3,1,1,0);
    // rst mid-run discards the partial run.
    add(0,0,1,0,1,0, 3,0,1,0);
    add(1,0,1,0,1,0, 0,0,0,0);
    add(0,0,1,0,1,0, 0,0,0,0);
    add(0,0,1,0,1,0, 0,0,0,0);
    add(0,0,1,0,1,0, 2,1,1,0);

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].e, tbl[i].g, tbl[i].l);
      chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].pl, tbl[i].ev, tbl[i].er);
    end

    // Event counter wraps after 2^EVT_W acceptances.
    cyc(1,0,0,0,0,0);
    for (int i = 0; i < (1 << EVT_W); i++) begin
      for (int k = 0; k < HOLD; k++) begin
        if (i % 2 == 0) cyc(0,0,1,0,1,0);
        else            cyc(0,0,1,0,0,1);
      end
      if (i == (1 << EVT_W) - 2) chk("wrap_pre evt", int'(evt_cnt), (1 << EVT_W) - 1);
    end
    chk("wrap evt", int'(evt_cnt), 0);
    chk("wrap pulse", int'(change_pulse), 1);
    chk("wrap state", int'(state_o), 3);

    // Random stimulus against the reference model.
    cyc(1,0,0,0,0,0);
    begin
      logic [2:0] flags;
      flags = 3'b010;
      for (int n = 0; n < 3000; n++) begin
        logic r, c, v;
        r = ($urandom_range(0, 199) == 0);
        c = ($urandom_range(0, 149) == 0);
        v = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 9))
            0: flags = 3'b000;
            1: flags = 3'b011;
            2: flags = 3'b111;
            3, 4, 5: flags = 3'b100;
            6, 7: flags = 3'b010;
            default: flags = 3'b001;
          endcase
        end
        cyc(r, c, v, flags[2], flags[1], flags[0]);
        chk_all($sformatf("rnd%0d", n), m_state, m_pulse, m_evt, m_err);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
